// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed 7-segment driver with frame-aligned BCD load.
// Optional leading-zero blanking via `LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 2500,
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic [4*NUM_DIGITS-1:0]   load_digits,
    input  logic [NUM_DIGITS-1:0]     load_dp,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_tick
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]        r_slot_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic                    r_pending_full;
    logic [4*NUM_DIGITS-1:0] r_pending_digits;
    logic [NUM_DIGITS-1:0]   r_pending_dp;
    logic [4*NUM_DIGITS-1:0] r_active_digits;
    logic [NUM_DIGITS-1:0]   r_active_dp;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_en;
    logic                    r_tick;

    logic                    w_slot_last;
    logic                    w_frame_end;
    logic                    w_load_fire;
    logic                    w_blank;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg_dec;
    logic                    w_lz_blank;

    assign load_ready  = !r_pending_full && !reset;
    assign w_load_fire = load_valid && load_ready;
    assign w_slot_last = (r_slot_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_frame_end = w_slot_last && (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_blank     = (r_slot_cnt < CNT_W'(BLANK_CYCLES));
    assign w_nibble    = r_active_digits[4*r_digit_idx +: 4];

    // Segment pattern g..a; non-BCD nibbles render dark.
    always_comb begin
        w_seg_dec = 7'h00;
        case (w_nibble)
            4'd0: w_seg_dec = 7'h3F;
            4'd1: w_seg_dec = 7'h06;
            4'd2: w_seg_dec = 7'h5B;
            4'd3: w_seg_dec = 7'h4F;
            4'd4: w_seg_dec = 7'h66;
            4'd5: w_seg_dec = 7'h6D;
            4'd6: w_seg_dec = 7'h7D;
            4'd7: w_seg_dec = 7'h07;
            4'd8: w_seg_dec = 7'h7F;
            4'd9: w_seg_dec = 7'h6F;
            default: w_seg_dec = 7'h00;
        endcase
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        w_lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        w_lz_blank = (r_digit_idx != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(r_digit_idx) && r_active_digits[4*i +: 4] != 4'd0) begin
                w_lz_blank = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt       <= '0;
            r_digit_idx      <= '0;
            r_pending_full   <= 1'b0;
            r_pending_digits <= '0;
            r_pending_dp     <= '0;
            r_active_digits  <= '0;
            r_active_dp      <= '0;
            r_seg            <= '0;
            r_dp             <= 1'b0;
            r_en             <= '0;
            r_tick           <= 1'b0;
        end else begin
            if (w_slot_last) begin
                r_slot_cnt  <= '0;
                r_digit_idx <= (r_digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_slot_cnt  <= r_slot_cnt + 1'b1;
            end

            // Ready is low while pending is full, so transfer and capture never collide.
            if (w_frame_end && r_pending_full) begin
                r_active_digits <= r_pending_digits;
                r_active_dp     <= r_pending_dp;
                r_pending_full  <= 1'b0;
            end else if (w_load_fire) begin
                r_pending_digits <= load_digits;
                r_pending_dp     <= load_dp;
                r_pending_full   <= 1'b1;
            end

            r_tick <= w_frame_end;
            if (w_blank) begin
                r_en  <= '0;
                r_seg <= '0;
                r_dp  <= 1'b0;
            end else begin
                r_en  <= NUM_DIGITS'(1) << r_digit_idx;
                r_seg <= w_lz_blank ? 7'h00 : w_seg_dec;
                r_dp  <= r_active_dp[r_digit_idx];
            end
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign digit_en   = r_en;
    assign frame_tick = r_tick;
endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Downstream display stage for the seconds counter. Accepts a packed 4-digit BCD word plus decimal points through a valid/ready handshake and time-multiplexes it onto one shared 7-segment bus with one-hot digit enables. New values are applied only at frame boundaries, so the display never tears. A blanking gap at the start of each digit slot suppresses ghosting.

Parameters:
NUM_DIGITS, 4, digits scanned; data width is 4*NUM_DIGITS.
SCAN_DIV, 2500, clk cycles per digit slot; must be at least BLANK_CYCLES+2.
BLANK_CYCLES, 16, cycles at the start of each slot with all enables and segments off.
CNT_W, 12, slot counter width; 2**CNT_W must exceed SCAN_DIV.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
load_valid  in  1  load_digits/load_dp valid
load_ready  out  1  pending slot empty; transfer occurs when load_valid&load_ready
load_digits  in  4*NUM_DIGITS  BCD, digit 0 (rightmost, least significant) in [3:0]
load_dp  in  NUM_DIGITS  decimal point per digit
seg_out  out  7  active-high segments, bit0=a … bit6=g
dp_out  out  1  active-high decimal point for the enabled digit
digit_en  out  NUM_DIGITS  one-hot active-high common enable, all zero while blanking
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset is synchronous, active-high, on clk. While reset is high and on the cycle it is sampled: slot_cnt=0, digit_idx=0, pending_full=0, active digits=0, active dp=0. Registered outputs reset to seg_out=0, dp_out=0, digit_en=0, frame_tick=0.
- load_ready = !pending_full && !reset (combinational).
- Handshake: on a cycle with load_valid&&load_ready, capture load_digits/load_dp into the pending register and set pending_full. load_valid without ready is ignored; the source holds its data. Only one pending word exists, with no overwrite.
- Counters: slot_cnt increments every cycle and wraps SCAN_DIV-1→0. On wrap, digit_idx increments and wraps NUM_DIGITS-1→0.
- Frame end: the cycle with slot_cnt==SCAN_DIV-1 and digit_idx==NUM_DIGITS-1. On that cycle:
  - If pending_full, copy pending→active and clear pending_full. load_ready rises on the next cycle.
  - frame_tick pulses on the following cycle (registered).
  - A handshake cannot coincide with the transfer because ready is low while pending_full is set.
- Output registers (1-cycle latency from counter state):
  - When slot_cnt<BLANK_CYCLES: digit_en=0, seg_out=0, dp_out=0.
  - Otherwise: digit_en=1<<digit_idx, seg_out=decode(active nibble[digit_idx]), dp_out=active dp[digit_idx].
- Decode table (hex, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles 10–15 decode to 00, and dp is still driven.
- First frame after reset shows all zeros, or per the optional feature.
- Reset mid-frame discards any pending word and any partially displayed frame. Output is blank on the next cycle.
- digit_en is never multi-hot.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: a digit i>0 whose nibble is 0 and whose higher digits are all 0 decodes to seg_out=00. Its dp_out is still driven and its digit_en still asserts. Digit 0 always displays.
- Undefined: every digit decodes normally, so 0 shows as 3F.

Test Plan:
- Reset, SCAN_DIV=8, BLANK_CYCLES=2. Release reset at cycle 0 → digit_en=0 for cycles 1–2, digit_en=0001 with seg_out=3F for cycles 3–8, then 0010 from cycle 11. frame_tick pulses at cycle 32.
- Load 0x1234, dp=0001, mid-frame → load_ready drops the next cycle. The display stays 0000 until frame end, then shows digit0=4 (seg 66, dp=1), digit1=3 (4F), digit2=2 (5B), digit3=1 (06). load_ready returns the cycle after the transfer.
- Back-to-back: load 0x1111, then hold load_valid with 0x2222 → 0x2222 is not accepted until the cycle after the 0x1111 frame transfer. Frame sequence: 1111, then 2222.
- Nibble 0xA, load 0x00A5 → digit1 seg_out=00, digit0=6D.
- Reset asserted during a pending load → the pending word is lost, the display is blank for one cycle, then restarts at 0000. load_ready=1 after release.
- LEADING_ZERO_BLANK_EN defined, load 0x0070 → digits 3 and 2 show 00, digit1=07, digit0=3F. Load 0x0000 → only digit0 shows 3F.
